// File: rtl/mux_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_sched_pkg
// Description : Shared types, sizes and round-robin pick helper for the
//               8-source byte-mux scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_sched_pkg;

    localparam int N_SRC    = 8;
    localparam int SEL_W    = 3;
    localparam int SCHED_DW = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_t;

    typedef logic [SCHED_DW-1:0] byte_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Walks downward so the last hit written is the one closest to ptr.
    function automatic pick_t rr_pick(input logic [N_SRC-1:0] req,
                                      input logic [SEL_W-1:0] ptr);
        pick_t            r;
        logic [SEL_W-1:0] cand;
        r = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                r.found = 1'b1;
                r.idx   = cand;
            end
        end
        return r;
    endfunction

    function automatic logic [N_SRC-1:0] src_onehot(input logic [SEL_W-1:0] idx);
        logic [N_SRC-1:0] m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multiplexer.sv
`default_nettype none
// ============================================================================
// Module      : multiplexer
// Description : 8:1 multiplexer of DW-bit words, purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module multiplexer #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] data [8],
    input  logic [2:0]    sel,
    output logic [DW-1:0] y
);

    assign y = data[sel];

endmodule
`default_nettype wire

// File: rtl/mux_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_scheduler
// Description : Round-robin arbiter sharing one 8:1 byte mux between eight
//               requesters, with burst-limited grants and a valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_SRC-1:0]     req,
    input  logic [DW-1:0]        din [N_SRC],
    output logic [N_SRC-1:0]     gnt,
    output logic [N_SRC-1:0]     ack,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic [SEL_W-1:0]     out_src,
    output logic                 busy
);

    localparam logic [3:0] c_burst_last = 4'(BURST - 1);

    sched_state_t     r_state;
    logic [N_SRC-1:0] r_gnt;
    logic [N_SRC-1:0] r_ack;
    logic             r_valid;
    logic [SEL_W-1:0] r_src;
    logic [SEL_W-1:0] r_ptr;
    logic [3:0]       r_beat_cnt;

    logic             w_accept;
    logic             w_keep;
    logic [SEL_W-1:0] w_next_ptr;
    pick_t            w_idle_pick;
    pick_t            w_rot_pick;

    always_comb begin
        w_accept    = r_valid & out_ready;
        w_keep      = req[r_src] && (r_beat_cnt < c_burst_last);
        w_next_ptr  = r_src + SEL_W'(1);
        w_idle_pick = rr_pick(req, r_ptr);
        // The source just served is excluded so others get the next slot.
        w_rot_pick  = rr_pick(req & ~src_onehot(r_src), w_next_ptr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_ack      <= '0;
            r_valid    <= 1'b0;
            r_src      <= '0;
            r_ptr      <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                IDLE: begin
                    if (w_idle_pick.found) begin
                        r_state    <= GRANT;
                        r_src      <= w_idle_pick.idx;
                        r_gnt      <= src_onehot(w_idle_pick.idx);
                        r_valid    <= 1'b1;
                        r_beat_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (w_accept) begin
                        r_ack <= r_gnt;
                        if (w_keep) begin
                            r_beat_cnt <= r_beat_cnt + 4'd1;
                        end else begin
                            r_ptr      <= w_next_ptr;
                            r_beat_cnt <= '0;
                            if (w_rot_pick.found) begin
                                r_src <= w_rot_pick.idx;
                                r_gnt <= src_onehot(w_rot_pick.idx);
                            end else if (!req[r_src]) begin
                                r_state <= IDLE;
                                r_valid <= 1'b0;
                                r_gnt   <= '0;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    multiplexer #(
        .DW (DW)
    ) u_mux (
        .data (din),
        .sel  (r_src),
        .y    (out_data)
    );

    assign gnt       = r_gnt;
    assign ack       = r_ack;
    assign out_valid = r_valid;
    assign out_src   = r_src;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire
